// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 write scheduler.
// Holds the index/colour widths, the scheduler state encoding and the
// brightness scaling function used when WS2812_SCHED_BRIGHTNESS_EN is defined.
package ws2812_pkg;

   localparam int LED_IDX_W = 8;
   localparam int RGB_W     = 24;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLEAR
   } sched_state_t;

   // Scale one colour byte by (brightness+1)/256; 255 is identity, 0 gives 0.
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'(c) * (16'(b) + 16'd1);
      return prod[15:8];
   endfunction

endpackage

// File: rtl/ws2812_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set request at or after 'ptr', wrapping modulo N.
// The rotating pointer itself is owned by the parent scheduler.
module ws2812_rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   // Walk the requesters starting at ptr and pick the first one that is valid.
   always_comb begin
      logic          found;
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/ws2812_write_sched.sv
// WS2812 write scheduler: shares the driver's single pixel-write port between
// N_REQ requesters with round-robin arbitration and adds a strip-clear sequencer.
// Optional feature macro: WS2812_SCHED_BRIGHTNESS_EN adds a 'brightness' input
// that scales request colours (clear writes are never scaled).
module ws2812_write_sched
   import ws2812_pkg::*;
#(
   parameter int                N_REQ     = 4,
   parameter int                NUM_LEDS  = 8,
   parameter logic [RGB_W-1:0]  CLEAR_RGB = 24'h000000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*LED_IDX_W-1:0] req_led,
   input  logic [N_REQ*RGB_W-1:0]     req_rgb,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       clear_start,
`ifdef WS2812_SCHED_BRIGHTNESS_EN
   input  logic [7:0]                 brightness,
`endif
   output logic                       clear_busy,
   output logic                       clear_done,
   output logic                       range_err,
   output logic [LED_IDX_W-1:0]       led_num,
   output logic [RGB_W-1:0]           rgb_data,
   output logic                       write
);

   localparam int                   PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW-1:0]        LAST_REQ = PW'(N_REQ - 1);
   localparam logic [LED_IDX_W-1:0] LAST_LED = LED_IDX_W'(NUM_LEDS - 1);

   sched_state_t         state_q;
   logic [PW-1:0]        rr_ptr_q;
   logic [PW-1:0]        rr_ptr_d;
   logic [LED_IDX_W-1:0] clr_idx_q;
   logic                 clear_pend_q;
   logic                 write_q;
   logic                 clear_done_q;
   logic                 range_err_q;
   logic [LED_IDX_W-1:0] led_num_q;
   logic [RGB_W-1:0]     rgb_data_q;

   logic [N_REQ-1:0]     grant;
   logic [PW-1:0]        grant_idx;
   logic                 xfer;
   logic                 in_range;
   logic [LED_IDX_W-1:0] sel_led_d;
   logic [RGB_W-1:0]     sel_raw_rgb;
   logic [RGB_W-1:0]     sel_rgb_d;

   ws2812_rr_arbiter #(
      .N  (N_REQ),
      .PW (PW)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grants only in IDLE with no clear outstanding, and never while in reset.
   assign req_ready = (reset_n && (state_q == IDLE) && !clear_pend_q) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign in_range  = (32'(sel_led_d) < 32'(NUM_LEDS));

   // Mux the granted requester's index/colour and work out the next pointer.
   always_comb begin
      sel_led_d   = '0;
      sel_raw_rgb = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_led_d   = req_led[LED_IDX_W*i +: LED_IDX_W];
            sel_raw_rgb = req_rgb[RGB_W*i +: RGB_W];
         end
      end
`ifdef WS2812_SCHED_BRIGHTNESS_EN
      sel_rgb_d = {scale8(sel_raw_rgb[23:16], brightness),
                   scale8(sel_raw_rgb[15:8],  brightness),
                   scale8(sel_raw_rgb[7:0],   brightness)};
`else
      sel_rgb_d = sel_raw_rgb;
`endif
      rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + PW'(1);
   end

   // Scheduler FSM with all driver-facing outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         clr_idx_q    <= '0;
         clear_pend_q <= 1'b0;
         write_q      <= 1'b0;
         clear_done_q <= 1'b0;
         range_err_q  <= 1'b0;
         led_num_q    <= '0;
         rgb_data_q   <= '0;
      end else begin
         write_q      <= 1'b0;
         clear_done_q <= 1'b0;
         range_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  state_q     <= WRITE;
                  rr_ptr_q    <= rr_ptr_d;
                  led_num_q   <= sel_led_d;
                  rgb_data_q  <= sel_rgb_d;
                  write_q     <= in_range;
                  range_err_q <= !in_range;
                  if (clear_start) begin
                     clear_pend_q <= 1'b1;
                  end
               end else if (clear_pend_q || clear_start) begin
                  state_q      <= CLEAR;
                  clear_pend_q <= 1'b1;
                  clr_idx_q    <= '0;
                  write_q      <= 1'b1;
                  led_num_q    <= '0;
                  rgb_data_q   <= CLEAR_RGB;
                  clear_done_q <= (LAST_LED == '0);
               end
            end
            WRITE: begin
               state_q <= IDLE;
               if (clear_start) begin
                  clear_pend_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_idx_q == LAST_LED) begin
                  state_q      <= IDLE;
                  clear_pend_q <= 1'b0;
                  clr_idx_q    <= '0;
               end else begin
                  clr_idx_q    <= clr_idx_q + 8'd1;
                  write_q      <= 1'b1;
                  led_num_q    <= clr_idx_q + 8'd1;
                  rgb_data_q   <= CLEAR_RGB;
                  clear_done_q <= ((clr_idx_q + 8'd1) == LAST_LED);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign clear_busy = clear_pend_q;
   assign clear_done = clear_done_q;
   assign range_err  = range_err_q;
   assign led_num    = led_num_q;
   assign rgb_data   = rgb_data_q;
   assign write      = write_q;

endmodule

// File: doc/ws2812_write_sched.md
# ws2812_write_sched

Write scheduler for the WS2812 pixel driver. It shares the driver's single pixel-write port (`led_num`, `rgb_data`, `write`) between N independent requesters using round-robin arbitration. It also provides a built-in strip-clear sequencer. It sits between pattern generators / top-level logic and the `ws2812` instance; its outputs connect directly to that instance.

## Interface
- `N_REQ`, default 4: number of requesters, valid range 1..8.
- `NUM_LEDS`, default 8: strip length; valid indices are 0..NUM_LEDS-1 (max 256).
- `CLEAR_RGB`, default 24'h000000: colour written by the clear sequencer.
- `clk`  in  1  system clock (16 MHz on target).
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester write request.
- `req_led`  in  N_REQ*8  per-requester LED index; requester i uses bits [8i+7:8i].
- `req_rgb`  in  N_REQ*24  per-requester colour; requester i uses bits [24i+23:24i].
- `req_ready`  out  N_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `clear_start`  in  1  single-cycle pulse that starts a full-strip clear.
- `clear_busy`  out  1  high while a clear is pending or running.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `range_err`  out  1  one-cycle pulse when an accepted request has index >= NUM_LEDS.
- `led_num`  out  8  to the driver's `led_num`.
- `rgb_data`  out  24  to the driver's `rgb_data`.
- `write`  out  1  to the driver's `write`; one-cycle strobe.

## Operation
- FSM states: IDLE, WRITE, CLEAR.
- **IDLE, no clear pending:**
  - If any `req_valid` is set, the round-robin arbiter raises exactly one `req_ready` bit, for the first valid requester at or after `rr_ptr`. This is combinational from `req_valid`, `rr_ptr` and the state.
  - On transfer: latch `req_led[i]` and `req_rgb[i]`, set `rr_ptr = (i+1) mod N_REQ`, go to WRITE.
- **WRITE (one cycle):**
  - Drive `write=1` with the latched index and colour. Return to IDLE.
  - If the latched index is >= NUM_LEDS: `write` stays 0, `range_err` pulses, and `rr_ptr` still advances.
- **Clear:**
  - A `clear_start` in any state sets `clear_pend`.
  - IDLE with `clear_pend` goes to CLEAR. Clear has priority over requests, and `req_ready` is all zeros while `clear_busy`.
- **CLEAR:**
  - Each cycle, `write=1`, `led_num=clr_idx`, `rgb_data=CLEAR_RGB`; `clr_idx` runs from 0 to NUM_LEDS-1.
  - After the last index: pulse `clear_done`, clear `clear_pend`, go to IDLE.
  - A `clear_start` received during CLEAR is ignored.
- `req_ready` is never asserted in WRITE or CLEAR.
- Index arithmetic: `clr_idx` is 8 bits and compares against NUM_LEDS-1, so it never wraps.

## Timing
- Reset values (asynchronous): state IDLE, `rr_ptr=0`, `clr_idx=0`, `clear_pend=0`, `write=0`, `led_num=0`, `rgb_data=0`, `clear_done=0`, `range_err=0`, `clear_busy=0`. `req_ready=0` is forced while `reset_n` is low.
- Latency: transfer in cycle T gives `write` in cycle T+1.
- Throughput: one request write every 2 cycles; clear runs at 1 write per cycle, for NUM_LEDS cycles.
- `clear_start` in cycle T with FSM in IDLE: `clear_busy` in T+1, first clear write in T+1, `clear_done` in T+NUM_LEDS.
- If the FSM is in WRITE at T, the whole sequence starts one cycle later.
- `clear_start` and a `req_valid` in the same IDLE cycle: the request is granted in that cycle and the clear follows the WRITE.
- Reset asserted mid-clear: the clear is aborted, with no `clear_done`.
- All outputs except `req_ready` are registered.

## Configuration
- `WS2812_SCHED_BRIGHTNESS_EN`:
  - When defined, adds input `brightness` [7:0].
  - Each colour byte c of a request write becomes `(c*(brightness+1))>>8`, computed into the WRITE-stage register, so latency is unchanged. 255 is identity; 0 gives `c>>8`, i.e. 0.
  - Clear writes are never scaled.
- When undefined: no port, and colours pass through unchanged.

## Structure
- Package `ws2812_pkg`:
  - `LED_IDX_W=8`, `RGB_W=24`.
  - State enum `sched_state_t` {IDLE, WRITE, CLEAR}.
  - Function `scale8` (brightness multiply).
- Sub-module `ws2812_rr_arbiter`: parameter N; inputs `req`, `ptr`; outputs one-hot `grant` and binary `grant_idx`. Purely combinational; `rr_ptr` lives in the parent.

## Test plan
- **Reset:** hold `reset_n=0` with `req_valid=4'hF` -> `req_ready=0`, `write=0`, `led_num=0`. Release -> `req_ready=4'b0001` in the first cycle.
- **Round-robin:** `req_valid=4'hF` held constant -> grants in order 0,1,2,3,0, one every 2 cycles. With `req_rgb[i]=i+1` and `req_led[i]=i`, writes are (0,1),(1,2),(2,3),(3,4).
- **Skip idle requester:** `rr_ptr=1`, `req_valid=4'b1001` -> grant 3, then 0.
- **Clear:** NUM_LEDS=8, `clear_start` while IDLE -> 8 consecutive writes, `led_num` 0..7, `rgb_data=0`; `clear_done` on the 8th cycle; `req_valid=4'hF` is stalled throughout; `req_ready=0001` resumes in the next cycle.
- **Range error:** `req_led=8'd9` with NUM_LEDS=8 -> `write` stays 0, `range_err` pulses at T+1, `rr_ptr` advances.
- **Brightness:** with the macro defined, `brightness=8'h7F` and `req_rgb=24'hFF8002` -> `rgb_data=24'h7F4001`.
